// File: rtl/mc_wb_arbiter.sv
// Writeback arbiter for one register-file port: merges the single-cycle pipe result with
// results held by multi-cycle units, drops squashed uops and stalls the pipe on unit starvation.
module mc_wb_arbiter #(
  parameter int NUM_UNITS  = 3,
  parameter int STARVE_LIM = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [75:0]             IN_branch,
  input  logic [87:0]             IN_pipeUop,
  input  logic [88*NUM_UNITS-1:0] IN_unitUop,
  output logic [NUM_UNITS-1:0]    OUT_wbAvail,
  output logic                    OUT_stallPipe,
  output logic [87:0]             OUT_uop
);

  localparam int PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam int CNT_W = $clog2(STARVE_LIM + 1);
  localparam logic [PTR_W-1:0] LAST_UNIT = PTR_W'(NUM_UNITS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(STARVE_LIM);
  localparam logic [CNT_W-1:0] CNT_EDGE  = CNT_W'(STARVE_LIM - 1);

  logic [PTR_W-1:0] rr_ptr;
  logic [CNT_W-1:0] starve_cnt;
  logic [87:0]      unit_uop [NUM_UNITS];
  logic [NUM_UNITS-1:0] cand;
  logic [NUM_UNITS-1:0] grant;
  logic             pipe_valid;
  logic             any_cand;
  logic             unit_win;
  logic [PTR_W-1:0] win_idx;
  logic [87:0]      win_uop;
  int               probe;
  logic [87:0]      out_next;
  logic [PTR_W-1:0] rr_next;
  logic [CNT_W-1:0] cnt_next;
  logic             stall_next;
  logic             starve_inc;
  logic             unused_branch_bits;

  assign unused_branch_bits = ^{IN_branch[75:44], IN_branch[36:1]};

  // Younger-than-branch test: 7-bit wraparound difference, strictly positive when read signed.
  function automatic logic squashed(input logic [87:0] uop, input logic [75:0] branch);
    logic [6:0] diff;
    diff = uop[43:37] - branch[43:37];
    return branch[0] && !diff[6] && (diff != 7'd0);
  endfunction

  always_comb begin
    pipe_valid = IN_pipeUop[0] && !squashed(IN_pipeUop, IN_branch);
    cand = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      unit_uop[i] = IN_unitUop[88*i +: 88];
      cand[i] = unit_uop[i][0] && !squashed(unit_uop[i], IN_branch);
    end
    any_cand = |cand;
  end

  // Pipe has no backpressure, so units only compete when the pipe slot is empty.
  always_comb begin
    grant    = '0;
    unit_win = 1'b0;
    win_idx  = '0;
    probe    = 0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      probe = (int'(rr_ptr) + k) % NUM_UNITS;
      if (!pipe_valid && !unit_win && cand[PTR_W'(probe)]) begin
        unit_win = 1'b1;
        win_idx  = PTR_W'(probe);
      end
    end
    if (unit_win) grant[win_idx] = 1'b1;
    win_uop = unit_uop[win_idx];
  end

  assign OUT_wbAvail = rst ? '0 : grant;

  always_comb begin
    out_next   = '0;
    rr_next    = rr_ptr;
    cnt_next   = starve_cnt;
    starve_inc = 1'b0;
    stall_next = 1'b0;

    if (pipe_valid) out_next = IN_pipeUop;
    else if (unit_win) out_next = win_uop;

    if (unit_win) rr_next = (win_idx == LAST_UNIT) ? '0 : win_idx + 1'b1;

    // The count freezes while the stall is already asserted, so one starvation episode stalls once.
    starve_inc = pipe_valid && any_cand && !OUT_stallPipe && (starve_cnt < CNT_MAX);
    if (unit_win || !any_cand) cnt_next = '0;
    else if (starve_inc) cnt_next = starve_cnt + 1'b1;

    stall_next = starve_inc && (starve_cnt == CNT_EDGE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      OUT_uop       <= '0;
      rr_ptr        <= '0;
      starve_cnt    <= '0;
      OUT_stallPipe <= 1'b0;
    end else begin
      OUT_uop       <= out_next;
      rr_ptr        <= rr_next;
      starve_cnt    <= cnt_next;
      OUT_stallPipe <= stall_next;
    end
  end

endmodule

// File: tb/tb_mc_wb_arbiter.sv
// Self-checking bench for mc_wb_arbiter: directed scenarios then randomized traffic,
// all compared against a queue-free behavioural model of the arbitration rules.
module tb_mc_wb_arbiter;

  localparam int NU  = 3;
  localparam int LIM = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [75:0]       branch;
  logic [87:0]       pipe_uop;
  logic [88*NU-1:0]  unit_bus;
  logic [NU-1:0]     wb_avail;
  logic              stall_pipe;
  logic [87:0]       out_uop;

  always #5 clk = ~clk;

  mc_wb_arbiter #(.NUM_UNITS(NU), .STARVE_LIM(LIM)) dut (
    .clk          (clk),
    .rst          (rst),
    .IN_branch    (branch),
    .IN_pipeUop   (pipe_uop),
    .IN_unitUop   (unit_bus),
    .OUT_wbAvail  (wb_avail),
    .OUT_stallPipe(stall_pipe),
    .OUT_uop      (out_uop)
  );

  int checks = 0;
  int fails  = 0;

  // Reference model state.
  int          m_rr;
  int          m_cnt;
  logic        m_stall;
  logic [87:0] m_out;
  logic [87:0] units [NU];
  logic [NU-1:0] exp_grant;
  int          exp_unit;
  logic        exp_pipe;

  function automatic logic [87:0] mkUop(input int sqn);
    return {$urandom, 7'($urandom), 5'($urandom), 7'(sqn), $urandom, 3'($urandom), 1'($urandom), 1'b1};
  endfunction

  function automatic logic [75:0] mkBranch(input bit valid, input int sqn);
    logic [75:0] b;
    b = {$urandom, $urandom, 12'($urandom)};
    b[43:37] = 7'(sqn);
    b[0] = valid;
    return b;
  endfunction

  function automatic bit isSquashed(input logic [87:0] u);
    int d;
    if (!branch[0]) return 1'b0;
    d = (int'(u[43:37]) - int'(branch[43:37]) + 128) % 128;
    return (d >= 1) && (d <= 63);
  endfunction

  task automatic check(input string tag, input logic [87:0] obs, input logic [87:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_rr = 0;
    m_cnt = 0;
    m_stall = 1'b0;
    m_out = '0;
  endtask

  // Drive the current bench-side uops and work out who should own the port this cycle.
  task automatic applyStimulus();
    for (int i = 0; i < NU; i++) unit_bus[88*i +: 88] = units[i];
    exp_pipe  = pipe_uop[0] && !isSquashed(pipe_uop);
    exp_grant = '0;
    exp_unit  = -1;
    if (!exp_pipe) begin
      for (int k = 0; k < NU; k++) begin
        int idx;
        idx = (m_rr + k) % NU;
        if (exp_unit < 0 && units[idx][0] && !isSquashed(units[idx])) exp_unit = idx;
      end
    end
    if (exp_unit >= 0) exp_grant[exp_unit] = 1'b1;
    #1;
  endtask

  task automatic checkOutput(input string tag);
    bit any;
    bit inc;
    logic [87:0] nxt_out;
    int nxt_cnt;
    int nxt_rr;
    logic nxt_stall;
    check({tag, " wbAvail"}, 88'(wb_avail), 88'(exp_grant));
    any = 1'b0;
    for (int i = 0; i < NU; i++) if (units[i][0] && !isSquashed(units[i])) any = 1'b1;
    nxt_out = exp_pipe ? pipe_uop : (exp_unit >= 0 ? units[exp_unit] : 88'd0);
    inc = exp_pipe && any && !m_stall && (m_cnt < LIM);
    nxt_stall = inc && (m_cnt == LIM - 1);
    nxt_cnt = (exp_unit >= 0 || !any) ? 0 : (inc ? m_cnt + 1 : m_cnt);
    nxt_rr = (exp_unit >= 0) ? (exp_unit + 1) % NU : m_rr;
    @(posedge clk);
    #1;
    m_out = nxt_out;
    m_cnt = nxt_cnt;
    m_rr = nxt_rr;
    m_stall = nxt_stall;
    if (exp_unit >= 0) units[exp_unit][0] = 1'b0;
    check({tag, " uop"}, out_uop, m_out);
    check({tag, " stall"}, 88'(stall_pipe), 88'(m_stall));
    @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1'b1;
    #1;
    modelReset();
    check("reset uop", out_uop, 88'd0);
    check("reset wbAvail", 88'(wb_avail), 88'd0);
    check("reset stall", 88'(stall_pipe), 88'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clearInputs();
    pipe_uop = '0;
    branch = '0;
    for (int i = 0; i < NU; i++) units[i] = '0;
  endtask

  initial begin
    rst = 1'b1;
    clearInputs();
    unit_bus = '0;
    modelReset();
    doReset();

    // Pipe/unit collision: pipe wins, unit1 follows once the pipe goes idle.
    pipe_uop = mkUop(5);
    units[1] = mkUop(3);
    applyStimulus();
    check("collide grant", 88'(wb_avail), 88'd0);
    checkOutput("collide");
    check("collide pipe out", out_uop, pipe_uop);
    pipe_uop = '0;
    applyStimulus();
    check("follow grant", 88'(wb_avail), 88'b010);
    checkOutput("follow");

    // Round-robin fairness with every unit continuously refilled.
    clearInputs();
    doReset();
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < NU; i++) if (!units[i][0]) units[i] = mkUop(20 + 3 * c + i);
      applyStimulus();
      check("rr grant", 88'(wb_avail), 88'(3'b001 << (c % NU)));
      checkOutput("rr");
    end

    // Flush at a unit, including the 127 -> 0 wrap.
    clearInputs();
    branch = mkBranch(1'b1, 10);
    units[0] = mkUop(11);
    units[2] = mkUop(10);
    applyStimulus();
    check("flush grant", 88'(wb_avail), 88'b100);
    checkOutput("flush");
    applyStimulus();
    checkOutput("flush hold");
    clearInputs();
    branch = mkBranch(1'b1, 126);
    units[0] = mkUop(127);
    units[1] = mkUop(0);
    units[2] = mkUop(125);
    applyStimulus();
    check("wrap grant", 88'(wb_avail), 88'b100);
    checkOutput("wrap");

    // Starvation: four pipe wins against a waiting unit raise one stall cycle.
    clearInputs();
    doReset();
    units[1] = mkUop(40);
    for (int c = 0; c < LIM; c++) begin
      pipe_uop = mkUop(41 + c);
      applyStimulus();
      checkOutput("starve");
    end
    check("starve stall high", 88'(stall_pipe), 88'd1);
    pipe_uop = '0;
    applyStimulus();
    check("starve drain", 88'(wb_avail), 88'b010);
    checkOutput("drain");
    check("starve stall low", 88'(stall_pipe), 88'd0);

    // Asynchronous reset while a unit grant is pending.
    clearInputs();
    units[1] = mkUop(50);
    applyStimulus();
    checkOutput("pre-reset");
    units[0] = mkUop(51);
    units[2] = mkUop(52);
    applyStimulus();
    #1;
    rst = 1'b1;
    #1;
    check("async uop valid", 88'(out_uop[0]), 88'd0);
    check("async wbAvail", 88'(wb_avail), 88'd0);
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus();
    check("post-reset grant", 88'(wb_avail), 88'b001);
    checkOutput("post-reset");

    // Randomized traffic with flushes and stall-respecting pipe.
    clearInputs();
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NU; i++)
        if (!units[i][0] && ($urandom % 2 == 0)) units[i] = mkUop(int'($urandom % 128));
      if (m_stall ? ($urandom % 8 == 0) : ($urandom % 3 != 0)) pipe_uop = mkUop(int'($urandom % 128));
      else pipe_uop = '0;
      branch = mkBranch(($urandom % 5 == 0), int'($urandom % 128));
      applyStimulus();
      checkOutput("random");
      for (int i = 0; i < NU; i++) if (isSquashed(units[i])) units[i][0] = 1'b0;
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
